// File: rtl/io_src_chk_gen_if.sv
// Purpose : 4-phase req/ack link carrying one address/data/redundancy message.
// Ports   : master drives addr/dat/red/req and samples ack; slave the reverse.
// Latency : n/a (wires only). Backpressure: the slave withholds ack to stall the master.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

interface io_src_chk_gen_if #(
  parameter int ASZ = `NS_ADDRESS_SIZE,
  parameter int DSZ = `NS_DATA_SIZE,
  parameter int RSZ = `NS_REDUN_SIZE
);
  logic [ASZ-1:0] addr;
  logic [DSZ-1:0] dat;
  logic [RSZ-1:0] red;
  logic           req;
  logic           ack;

  modport master (output addr, output dat, output red, output req, input ack);
  modport slave  (input addr, input dat, input red, input req, output ack);
endinterface

// File: rtl/io_src_chk_gen.sv
// Purpose : loop-test endpoint; o0 generates an ordered (addr,dat) stream, i0 checks one.
// Latency : >=3 cycles per generated message; checker acks one cycle after seeing req.
// Backpressure: 4-phase links; generator waits on o0.ack, checker holds ack until req drops.
// Ports   : i_clk, reset (sync, active-high), ready, i_run, o0 (link master),
//           i0 (link slave), i0_ck_dat, err_0/1/2, fst_err0_inp/dat, snd_cnt, rcv_cnt.
// Option  : define NS_SRC_CHK_WDOG_EN to enable the handshake watchdog (err_2).
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

module io_src_chk_gen #(
  parameter int ASZ      = `NS_ADDRESS_SIZE,
  parameter int DSZ      = `NS_DATA_SIZE,
  parameter int RSZ      = `NS_REDUN_SIZE,
  parameter int MIN_ADDR = 0,
  parameter int MAX_ADDR = 55,
  parameter int CNT_SZ   = 16,
  parameter int TMO_CYC  = 1024
) (
  input  logic                 i_clk,
  input  logic                 reset,
  output logic                 ready,
  input  logic                 i_run,
  io_src_chk_gen_if.master     o0,
  io_src_chk_gen_if.slave      i0,
  output logic [DSZ-1:0]       i0_ck_dat,
  output logic                 err_0,
  output logic                 err_1,
  output logic                 err_2,
  output logic [DSZ-1:0]       fst_err0_inp,
  output logic [DSZ-1:0]       fst_err0_dat,
  output logic [CNT_SZ-1:0]    snd_cnt,
  output logic [CNT_SZ-1:0]    rcv_cnt
);

  // Elaboration-time sanity check of the parameter set.
  if (RSZ > DSZ || RSZ > ASZ || MIN_ADDR > MAX_ADDR || MAX_ADDR >= (1 << ASZ) || TMO_CYC < 1) begin : g_bad_param
    $error("io_src_chk_gen: illegal parameter combination");
  end

  localparam logic [ASZ-1:0] MIN_A = ASZ'(MIN_ADDR);
  localparam logic [ASZ-1:0] MAX_A = ASZ'(MAX_ADDR);

  typedef enum logic [1:0] {G_IDLE, G_REQ, G_REL} g_state_e;
  typedef enum logic       {C_IDLE, C_ACK}        c_state_e;

  // ---------------- generator ----------------
  g_state_e          g_state_q;
  logic [ASZ-1:0]    g_addr_q, g_addr_d;
  logic [DSZ-1:0]    g_dat_q,  g_dat_d;
  logic              g_req_q;
  logic [CNT_SZ-1:0] snd_cnt_q;
  logic              ready_q;

  assign g_addr_d = (g_addr_q == MAX_A) ? MIN_A : g_addr_q + 1'b1;
  assign g_dat_d  = g_dat_q + 1'b1;

  always_ff @(posedge i_clk) begin
    if (reset) begin
      g_state_q <= G_IDLE;
      g_addr_q  <= MIN_A;
      g_dat_q   <= '0;
      g_req_q   <= 1'b0;
      snd_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      case (g_state_q)
        G_IDLE: if (i_run) begin
          g_req_q   <= 1'b1;
          g_state_q <= G_REQ;
        end
        G_REQ: if (o0.ack) begin
          g_req_q   <= 1'b0;
          g_state_q <= G_REL;
        end
        G_REL: if (!o0.ack) begin
          g_addr_q  <= g_addr_d;
          g_dat_q   <= g_dat_d;
          if (snd_cnt_q != '1) snd_cnt_q <= snd_cnt_q + 1'b1;
          g_state_q <= G_IDLE;
        end
        default: g_state_q <= G_IDLE;
      endcase
    end
  end

  // Payload comes straight from registers, so it is stable for the whole req window.
  assign o0.addr = g_addr_q;
  assign o0.dat  = g_dat_q;
  assign o0.red  = g_addr_q[RSZ-1:0] ^ g_dat_q[RSZ-1:0];
  assign o0.req  = g_req_q;
  assign ready   = ready_q;
  assign snd_cnt = snd_cnt_q;

  // ---------------- checker ----------------
  c_state_e          c_state_q;
  logic [ASZ-1:0]    c_addr_q, c_addr_d;
  logic [DSZ-1:0]    c_dat_q,  c_dat_d;
  logic              c_ack_q;
  logic              err_0_q, err_1_q;
  logic [DSZ-1:0]    fst_inp_q, fst_dat_q;
  logic [CNT_SZ-1:0] rcv_cnt_q;
  logic              hit_0, hit_1;

  assign c_addr_d = (c_addr_q == MAX_A) ? MIN_A : c_addr_q + 1'b1;
  assign c_dat_d  = c_dat_q + 1'b1;
  assign hit_0    = (i0.addr != c_addr_q) || (i0.dat != c_dat_q);
  assign hit_1    = i0.red != (i0.addr[RSZ-1:0] ^ i0.dat[RSZ-1:0]);

  always_ff @(posedge i_clk) begin
    if (reset) begin
      c_state_q <= C_IDLE;
      c_addr_q  <= MIN_A;
      c_dat_q   <= '0;
      c_ack_q   <= 1'b0;
      err_0_q   <= 1'b0;
      err_1_q   <= 1'b0;
      fst_inp_q <= '0;
      fst_dat_q <= '0;
      rcv_cnt_q <= '0;
    end else begin
      case (c_state_q)
        C_IDLE: if (i0.req) begin
          c_ack_q   <= 1'b1;
          c_state_q <= C_ACK;
          if (hit_0) err_0_q <= 1'b1;
          if (hit_1) err_1_q <= 1'b1;
          // Snapshot only the very first failing message.
          if ((hit_0 || hit_1) && !err_0_q && !err_1_q) begin
            fst_inp_q <= c_dat_q;
            fst_dat_q <= i0.dat;
          end
        end
        C_ACK: if (!i0.req) begin
          c_ack_q   <= 1'b0;
          // Expected sequence advances even after a bad message.
          c_addr_q  <= c_addr_d;
          c_dat_q   <= c_dat_d;
          if (rcv_cnt_q != '1) rcv_cnt_q <= rcv_cnt_q + 1'b1;
          c_state_q <= C_IDLE;
        end
        default: c_state_q <= C_IDLE;
      endcase
    end
  end

  assign i0.ack       = c_ack_q;
  assign i0_ck_dat    = c_dat_q;
  assign err_0        = err_0_q;
  assign err_1        = err_1_q;
  assign fst_err0_inp = fst_inp_q;
  assign fst_err0_dat = fst_dat_q;
  assign rcv_cnt      = rcv_cnt_q;

`ifdef NS_SRC_CHK_WDOG_EN
  // ---------------- watchdog ----------------
  // Each counter spans one whole handshake and clears when its FSM is idle.
  // err_2 flags the TMO_CYC-th consecutive waiting cycle; the FSMs are not disturbed.
  localparam int TW = $clog2(TMO_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

  logic [TW-1:0] g_tmo_q, c_tmo_q;
  logic          err_2_q;
  logic          g_wait, c_wait;

  assign g_wait = (g_state_q != G_IDLE);
  assign c_wait = (c_state_q == C_ACK);

  always_ff @(posedge i_clk) begin
    if (reset) begin
      g_tmo_q <= '0;
      c_tmo_q <= '0;
      err_2_q <= 1'b0;
    end else begin
      if (!g_wait) g_tmo_q <= '0;
      else if (g_tmo_q != TMO_LAST + 1'b1) g_tmo_q <= g_tmo_q + 1'b1;
      if (!c_wait) c_tmo_q <= '0;
      else if (c_tmo_q != TMO_LAST + 1'b1) c_tmo_q <= c_tmo_q + 1'b1;
      if ((g_wait && g_tmo_q == TMO_LAST) || (c_wait && c_tmo_q == TMO_LAST)) err_2_q <= 1'b1;
    end
  end

  assign err_2 = err_2_q;
`else
  assign err_2 = 1'b0;
`endif

endmodule
